vga_timing_gen: RTL and testbench

- Upstream pixel-timing source for all sprite/ROM display stages on vga_clk.
- Generates DrawX/DrawY raster coordinates, the display-enable `blank`, and active-low HS/VS for 640x480@60.
- Provides sync/enable copies delayed to line up with the downstream sprite pipeline: 1-cycle sync ROM read plus 1-cycle registered RGB.
- Also emits a frame-start pulse and a frame counter for game-logic animation.

---
 rtl/vga_timing_pkg.sv | 34 +++
 rtl/vga_sync_delay.sv | 51 +++++
 rtl/vga_timing_gen.sv | 180 ++++++++++++++++++
 tb/tb_vga_timing_gen.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
//------------------------------------------------------------------------------
// Module  : vga_timing_pkg
// Purpose : Default 640x480@60 raster timing constants, coordinate width and
//           the coordinate type shared by the VGA timing generator files.
// Ports   : none (package)
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package vga_timing_pkg;

  localparam int COORD_W = 10;
  typedef logic [COORD_W-1:0] coord_t;

  localparam int H_VISIBLE_DEF = 640;
  localparam int H_FP_DEF      = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BP_DEF      = 48;
  localparam int H_TOTAL_DEF   = H_VISIBLE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;

  localparam int V_VISIBLE_DEF = 480;
  localparam int V_FP_DEF      = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BP_DEF      = 33;
  localparam int V_TOTAL_DEF   = V_VISIBLE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  localparam int PIPE_DLY_DEF  = 2;

  // Width of one colour bar of the bring-up test pattern.
  localparam int BAR_PIX       = 80;

endpackage

`default_nettype wire

// File: rtl/vga_sync_delay.sv
//------------------------------------------------------------------------------
// Module  : vga_sync_delay
// Purpose : Fixed-depth shift register that delays a bundle of sync/enable
//           bits so they line up with a downstream pixel pipeline.
// Ports   : clk_i   - clock
//           rst_i   - asynchronous active-high reset, loads RST_VAL
//           d_i     - bundle input
//           q_o     - bundle delayed by DEPTH cycles (DEPTH=0: pass-through)
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module vga_sync_delay #(
  parameter int               WIDTH   = 3,
  parameter int               DEPTH   = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  generate
    if (DEPTH == 0) begin : g_pass
      assign q_o = d_i;
    end else begin : g_shift
      logic [WIDTH-1:0] stage_q [DEPTH];

      // Every stage resets to the inactive value so the first DEPTH cycles
      // after reset present an idle display rather than stale sync.
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          for (int i = 0; i < DEPTH; i++) begin
            stage_q[i] <= RST_VAL;
          end
        end else begin
          stage_q[0] <= d_i;
          for (int i = 1; i < DEPTH; i++) begin
            stage_q[i] <= stage_q[i-1];
          end
        end
      end

      assign q_o = stage_q[DEPTH-1];
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/vga_timing_gen.sv
//------------------------------------------------------------------------------
// Module  : vga_timing_gen
// Purpose : 640x480@60 raster timing source. Produces DrawX/DrawY, display
//           enable, active-low HS/VS, pipeline-delayed copies of the syncs,
//           a frame-start pulse and an 8-bit frame counter.
// Ports   : vga_clk      - pixel clock
//           reset        - asynchronous active-high reset
//           DrawX/DrawY  - current column / line
//           blank/hs/vs  - enable and syncs aligned with DrawX/DrawY
//           blank_d/hs_d/vs_d - same, delayed PIPE_DLY cycles
//           frame_start  - one-cycle pulse when the raster wraps to (0,0)
//           frame_count  - frames since reset, modulo 256
//           pat_red/pat_green/pat_blue - 8-bar test pattern aligned with
//                          blank_d (only when VGA_TIMING_PATTERN_EN is defined)
// Config  : `define VGA_TIMING_PATTERN_EN adds the colour-bar pattern outputs.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE = H_VISIBLE_DEF,
  parameter int H_FP      = H_FP_DEF,
  parameter int H_SYNC    = H_SYNC_DEF,
  parameter int H_BP      = H_BP_DEF,
  parameter int V_VISIBLE = V_VISIBLE_DEF,
  parameter int V_FP      = V_FP_DEF,
  parameter int V_SYNC    = V_SYNC_DEF,
  parameter int V_BP      = V_BP_DEF,
  parameter int PIPE_DLY  = PIPE_DLY_DEF
) (
  input  logic       vga_clk,
  input  logic       reset,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       blank,
  output logic       hs,
  output logic       vs,
  output logic       blank_d,
  output logic       hs_d,
  output logic       vs_d,
  output logic       frame_start,
  output logic [7:0] frame_count
`ifdef VGA_TIMING_PATTERN_EN
  ,
  output logic [3:0] pat_red,
  output logic [3:0] pat_green,
  output logic [3:0] pat_blue
`endif
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam coord_t C_H_LAST   = coord_t'(H_TOTAL - 1);
  localparam coord_t C_V_LAST   = coord_t'(V_TOTAL - 1);
  localparam coord_t C_H_VIS    = coord_t'(H_VISIBLE);
  localparam coord_t C_V_VIS    = coord_t'(V_VISIBLE);
  localparam coord_t C_HS_START = coord_t'(H_VISIBLE + H_FP);
  localparam coord_t C_HS_END   = coord_t'(H_VISIBLE + H_FP + H_SYNC);
  localparam coord_t C_VS_START = coord_t'(V_VISIBLE + V_FP);
  localparam coord_t C_VS_END   = coord_t'(V_VISIBLE + V_FP + V_SYNC);

  coord_t     x_q, y_q, x_d, y_d;
  logic       vis_q, hsync_q, vsync_q;
  logic       vis_d, hsync_d, vsync_d, wrap_d;
  logic       fstart_q;
  logic [7:0] fcount_q;

  // Next raster position; outputs below are derived from it so that the
  // registered syncs describe the same pixel as the registered counters.
  always_comb begin
    x_d    = x_q + 10'd1;
    y_d    = y_q;
    wrap_d = 1'b0;
    if (x_q == C_H_LAST) begin
      x_d = '0;
      if (y_q == C_V_LAST) begin
        y_d    = '0;
        wrap_d = 1'b1;
      end else begin
        y_d = y_q + 10'd1;
      end
    end
  end

  always_comb begin
    vis_d   = (x_d < C_H_VIS) && (y_d < C_V_VIS);
    hsync_d = !((x_d >= C_HS_START) && (x_d < C_HS_END));
    vsync_d = !((y_d >= C_VS_START) && (y_d < C_VS_END));
  end

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      x_q      <= '0;
      y_q      <= '0;
      vis_q    <= 1'b0;
      hsync_q  <= 1'b1;
      vsync_q  <= 1'b1;
      fstart_q <= 1'b0;
      fcount_q <= 8'd0;
    end else begin
      x_q      <= x_d;
      y_q      <= y_d;
      vis_q    <= vis_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      // (0,0) is only reached through a wrap once out of reset, so the
      // reset-entry origin never raises the pulse.
      fstart_q <= wrap_d;
      if (wrap_d) begin
        fcount_q <= fcount_q + 8'd1;
      end
    end
  end

  assign DrawX       = x_q;
  assign DrawY       = y_q;
  assign blank       = vis_q;
  assign hs          = hsync_q;
  assign vs          = vsync_q;
  assign frame_start = fstart_q;
  assign frame_count = fcount_q;

`ifdef VGA_TIMING_PATTERN_EN
  // Pattern colour bits ride in the same delay line as the syncs so they stay
  // aligned with blank_d; they are already zero whenever blank is zero.
  localparam int               BUNDLE_W   = 6;
  localparam logic [BUNDLE_W-1:0] BUNDLE_RST = 6'b011_000;
  localparam coord_t           C_BAR      = coord_t'(BAR_PIX);

  logic [2:0] rgb_d, rgb_q;

  always_comb begin
    rgb_d = 3'b000;
    if (vis_d) begin
      rgb_d = 3'(x_d / C_BAR);
    end
  end

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      rgb_q <= 3'b000;
    end else begin
      rgb_q <= rgb_d;
    end
  end

  logic [BUNDLE_W-1:0] bundle_in, bundle_out;
  assign bundle_in = {vis_q, hsync_q, vsync_q, rgb_q};
  assign pat_red   = {4{bundle_out[0]}};
  assign pat_green = {4{bundle_out[1]}};
  assign pat_blue  = {4{bundle_out[2]}};
`else
  localparam int               BUNDLE_W   = 3;
  localparam logic [BUNDLE_W-1:0] BUNDLE_RST = 3'b011;

  logic [BUNDLE_W-1:0] bundle_in, bundle_out;
  assign bundle_in = {vis_q, hsync_q, vsync_q};
`endif

  vga_sync_delay #(
    .WIDTH   (BUNDLE_W),
    .DEPTH   (PIPE_DLY),
    .RST_VAL (BUNDLE_RST)
  ) u_sync_delay (
    .clk_i (vga_clk),
    .rst_i (reset),
    .d_i   (bundle_in),
    .q_o   (bundle_out)
  );

  assign blank_d = bundle_out[BUNDLE_W-1];
  assign hs_d    = bundle_out[BUNDLE_W-2];
  assign vs_d    = bundle_out[BUNDLE_W-3];

endmodule

`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
//------------------------------------------------------------------------------
// Module  : tb_vga_timing_gen
// Purpose : Directed self-checking bench for vga_timing_gen, run on a reduced
//           raster (15x10 total, 8x6 visible) so full frames and the 8-bit
//           frame counter wrap fit in a short simulation.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_vga_timing_gen;

  localparam int HV  = 8;
  localparam int HFP = 2;
  localparam int HSY = 3;
  localparam int HBP = 2;
  localparam int HT  = HV + HFP + HSY + HBP;   // 15
  localparam int VV  = 6;
  localparam int VFP = 1;
  localparam int VSY = 2;
  localparam int VBP = 1;
  localparam int VT  = VV + VFP + VSY + VBP;   // 10
  localparam int DLY = 2;
  localparam int FRAME = HT * VT;               // 150

  logic       vga_clk = 1'b0;
  logic       reset   = 1'b1;
  logic [9:0] DrawX, DrawY;
  logic       blank, hs, vs, blank_d, hs_d, vs_d, frame_start;
  logic [7:0] frame_count;

  int errors = 0;
  int checks = 0;
  int n      = 0;   // clock edges since reset release

  always #5 vga_clk = ~vga_clk;

  vga_timing_gen #(
    .H_VISIBLE (HV), .H_FP (HFP), .H_SYNC (HSY), .H_BP (HBP),
    .V_VISIBLE (VV), .V_FP (VFP), .V_SYNC (VSY), .V_BP (VBP),
    .PIPE_DLY  (DLY)
  ) dut (
    .vga_clk     (vga_clk),
    .reset       (reset),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .blank       (blank),
    .hs          (hs),
    .vs          (vs),
    .blank_d     (blank_d),
    .hs_d        (hs_d),
    .vs_d        (vs_d),
    .frame_start (frame_start),
    .frame_count (frame_count)
  );

  // Reference raster: k edges after release; k<=0 is the reset state.
  function automatic int fx(input int k);
    return (k <= 0) ? 0 : k % HT;
  endfunction
  function automatic int fy(input int k);
    return (k <= 0) ? 0 : (k / HT) % VT;
  endfunction
  function automatic logic fblank(input int k);
    if (k <= 0) return 1'b0;
    return (fx(k) < HV) && (fy(k) < VV);
  endfunction
  function automatic logic fhs(input int k);
    if (k <= 0) return 1'b1;
    return !((fx(k) >= HV + HFP) && (fx(k) < HV + HFP + HSY));
  endfunction
  function automatic logic fvs(input int k);
    if (k <= 0) return 1'b1;
    return !((fy(k) >= VV + VFP) && (fy(k) < VV + VFP + VSY));
  endfunction

  task automatic adv();
    @(negedge vga_clk);
    n++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge vga_clk);
    @(negedge vga_clk);
    reset = 1'b0;
    n = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(negedge vga_clk);
    @(negedge vga_clk);
    checks++; if (DrawX !== 10'd0) begin errors++; $display("FAIL reset_DrawX: got %0d expected 0", DrawX); end
    checks++; if (DrawY !== 10'd0) begin errors++; $display("FAIL reset_DrawY: got %0d expected 0", DrawY); end
    checks++; if (blank !== 1'b0) begin errors++; $display("FAIL reset_blank: got %b expected 0", blank); end
    checks++; if (hs !== 1'b1) begin errors++; $display("FAIL reset_hs: got %b expected 1", hs); end
    checks++; if (vs !== 1'b1) begin errors++; $display("FAIL reset_vs: got %b expected 1", vs); end
    checks++; if (blank_d !== 1'b0) begin errors++; $display("FAIL reset_blank_d: got %b expected 0", blank_d); end
    checks++; if (hs_d !== 1'b1) begin errors++; $display("FAIL reset_hs_d: got %b expected 1", hs_d); end
    checks++; if (vs_d !== 1'b1) begin errors++; $display("FAIL reset_vs_d: got %b expected 1", vs_d); end
    checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL reset_frame_start: got %b expected 0", frame_start); end
    checks++; if (frame_count !== 8'd0) begin errors++; $display("FAIL reset_frame_count: got %0d expected 0", frame_count); end
    reset = 1'b0;
    n = 0;
  endtask

  // Two lines from release: coordinates, line wrap and visible window.
  task automatic test_count();
    for (int k = 1; k <= 2 * HT; k++) begin
      adv();
      checks++; if (DrawX !== 10'(fx(n))) begin errors++; $display("FAIL count_DrawX n=%0d: got %0d expected %0d", n, DrawX, fx(n)); end
      checks++; if (DrawY !== 10'(fy(n))) begin errors++; $display("FAIL count_DrawY n=%0d: got %0d expected %0d", n, DrawY, fy(n)); end
      checks++; if (blank !== fblank(n)) begin errors++; $display("FAIL count_blank n=%0d: got %b expected %b", n, blank, fblank(n)); end
      if (n == HV - 1) begin
        checks++; if (blank !== 1'b1) begin errors++; $display("FAIL blank_last_visible: got %b expected 1", blank); end
      end
      if (n == HV) begin
        checks++; if (blank !== 1'b0) begin errors++; $display("FAIL blank_first_porch: got %b expected 0", blank); end
      end
      if (n == HT) begin
        checks++; if ({DrawX, DrawY} !== {10'd0, 10'd1}) begin errors++; $display("FAIL line_wrap: got (%0d,%0d) expected (0,1)", DrawX, DrawY); end
      end
    end
  endtask

  task automatic test_hsync();
    int lows = 0;
    for (int k = 0; k < HT; k++) begin
      adv();
      if (hs === 1'b0) lows++;
      checks++; if (hs !== fhs(n)) begin errors++; $display("FAIL hsync x=%0d: got %b expected %b", fx(n), hs, fhs(n)); end
    end
    checks++; if (lows !== HSY) begin errors++; $display("FAIL hsync_width: got %0d expected %0d", lows, HSY); end
  endtask

  task automatic test_vsync();
    int lows = 0;
    int vis  = 0;
    for (int k = 0; k < FRAME; k++) begin
      adv();
      if (vs === 1'b0) lows++;
      if (blank === 1'b1) vis++;
      checks++; if (vs !== fvs(n)) begin errors++; $display("FAIL vsync y=%0d: got %b expected %b", fy(n), vs, fvs(n)); end
      if (fy(n) >= VV) begin
        checks++; if (blank !== 1'b0) begin errors++; $display("FAIL vblank y=%0d: got %b expected 0", fy(n), blank); end
      end
    end
    checks++; if (lows !== VSY * HT) begin errors++; $display("FAIL vsync_width: got %0d expected %0d", lows, VSY * HT); end
    checks++; if (vis !== HV * VV) begin errors++; $display("FAIL visible_pixels: got %0d expected %0d", vis, HV * VV); end
  endtask

  task automatic test_delay();
    do_reset();
    for (int k = 1; k <= 2 * FRAME; k++) begin
      adv();
      if (n <= DLY) begin
        checks++; if (blank_d !== 1'b0) begin errors++; $display("FAIL delay_startup n=%0d: got %b expected 0", n, blank_d); end
      end
      checks++; if (blank_d !== fblank(n - DLY)) begin errors++; $display("FAIL blank_d n=%0d: got %b expected %b", n, blank_d, fblank(n - DLY)); end
      checks++; if (hs_d !== fhs(n - DLY)) begin errors++; $display("FAIL hs_d n=%0d: got %b expected %b", n, hs_d, fhs(n - DLY)); end
      checks++; if (vs_d !== fvs(n - DLY)) begin errors++; $display("FAIL vs_d n=%0d: got %b expected %b", n, vs_d, fvs(n - DLY)); end
    end
  endtask

  // 257 frames: pulse spacing, single-cycle width, counter and its wrap.
  task automatic test_frame();
    int  cnt;
    logic seen;
    do_reset();
    cnt = 0;
    for (int f = 1; f <= 257; f++) begin
      seen = 1'b0;
      while (!seen && cnt < 2 * FRAME) begin
        adv();
        cnt++;
        if (frame_start === 1'b1) seen = 1'b1;
      end
      checks++; if (cnt !== FRAME) begin errors++; $display("FAIL frame_period f=%0d: got %0d expected %0d", f, cnt, FRAME); end
      checks++; if (frame_count !== 8'(f)) begin errors++; $display("FAIL frame_count f=%0d: got %0d expected %0d", f, frame_count, f % 256); end
      if (f == 256) begin
        checks++; if (frame_count !== 8'd0) begin errors++; $display("FAIL frame_count_wrap: got %0d expected 0", frame_count); end
      end
      checks++; if ({DrawX, DrawY} !== 20'd0) begin errors++; $display("FAIL frame_origin: got (%0d,%0d) expected (0,0)", DrawX, DrawY); end
      adv();
      checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL frame_pulse_width f=%0d: got %b expected 0", f, frame_start); end
      cnt = 1;
    end
  endtask

  task automatic test_midreset();
    do_reset();
    while (n < FRAME + 3 * HT + 4) adv();
    checks++; if ({DrawX, DrawY, blank, frame_count} !== {10'd4, 10'd3, 1'b1, 8'd1}) begin
      errors++; $display("FAIL midreset_pre: got x=%0d y=%0d blank=%b fc=%0d expected x=4 y=3 blank=1 fc=1", DrawX, DrawY, blank, frame_count);
    end
    #2 reset = 1'b1;
    #1;
    checks++; if ({DrawX, DrawY} !== 20'd0) begin errors++; $display("FAIL midreset_xy: got (%0d,%0d) expected (0,0)", DrawX, DrawY); end
    checks++; if ({blank, hs, vs} !== 3'b011) begin errors++; $display("FAIL midreset_sync: got %b expected 011", {blank, hs, vs}); end
    checks++; if ({blank_d, hs_d, vs_d} !== 3'b011) begin errors++; $display("FAIL midreset_sync_d: got %b expected 011", {blank_d, hs_d, vs_d}); end
    checks++; if ({frame_start, frame_count} !== 9'd0) begin errors++; $display("FAIL midreset_frame: got fs=%b fc=%0d expected 0 0", frame_start, frame_count); end
    @(negedge vga_clk);
    reset = 1'b0;
    n = 0;
    adv();
    checks++; if ({DrawX, DrawY} !== {10'd1, 10'd0}) begin errors++; $display("FAIL restart_xy: got (%0d,%0d) expected (1,0)", DrawX, DrawY); end
    checks++; if (frame_count !== 8'd0) begin errors++; $display("FAIL restart_frame_count: got %0d expected 0", frame_count); end
  endtask

  initial begin
    test_reset();
    test_count();
    test_hsync();
    test_vsync();
    test_delay();
    test_frame();
    test_midreset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
